calc_core_n: RTL and testbench
==============================

// Module: calc_core_n
// PURPOSE
//  Parametrised calculator core: N-digit decimal operand entry from a one-hot keypad, strobed
//  by set, then one of add/sub/mul/div, a second operand and an equals strobe.
//  Computes a binary result and converts it to BCD for the text-LCD driver and status LEDs.
//  Next generation of the single-digit textlcd calculator.
//  Adds multi-digit operands, iterative divide, a sign flag, an error state and a BCD result.
// PARAMETERS
//  DIGITS  4   max decimal digits per operand
//  OPW     14  operand width; must satisfy 2**OPW >= 10**DIGITS
//  RESW    28  result width, = 2*OPW
// PORTS
//  clk       in   1           system clock (50 MHz)
//  rst_n     in   1           synchronous reset, active-low
//  set       in   1           entry strobe (level); acts on its rising edge only, detected internally
//  KEY       in   10          one-hot digit key: bit d = digit d
//  Add/Sub/Mul/Div in 1 each  operator select, sampled on a set edge
//  clr       in   1           synchronous clear, priority over set
//  disp_bcd  out  4*2*DIGITS  displayed value in BCD (entry operand or result)
//  disp_neg  out  1           result is negative
//  res_bin   out  RESW        result magnitude, binary
//  busy      out  1           compute or BCD conversion in progress
//  valid     out  1           1-cycle pulse when disp_bcd holds a new result
//  err       out  1           error state (divide by zero / chain overflow)
//  led       out  5           one-hot state: {ERR,DONE,CALC,B,A}
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge) or clr=1:
//   - state=S_A; operands, op and entry count cleared to 0.
//   - disp_bcd=0, disp_neg=0, res_bin=0, busy=0, valid=0, err=0, led=5'b00001.
//   - Any operation in flight is aborted with no valid pulse.
//  Edge detect: se = set & ~set_d (set_d registered); all entry actions occur on the se cycle.
//  Decode on se: digit = KEY one-hot with all op bits 0; op = exactly one op bit set with KEY==0.
//   Equals = KEY==0 and no op bit set. Any other combination (multi-hot, key+op) is ignored.
//  S_A: digit -> A=A*10+d, BCD entry shifted left one nibble with d in the low nibble.
//   Digit is ignored once DIGITS digits have been entered. op -> latch op, entry cleared, S_B.
//   Equals is ignored.
//  S_B: digit -> same entry rule applied to B.
//   Equals -> S_CALC with busy=1 on the next cycle. op is ignored.
//  S_CALC: add/sub/mul take 1 cycle.
//   Sub with A<B: magnitude=B-A, disp_neg=1.
//   Div: restoring divide over OPW cycles, quotient only. B==0 -> S_ERR next cycle, no compute.
//  Then double-dabble BCD conversion, RESW cycles.
//   On the last cycle: disp_bcd = result, valid=1 for one cycle, busy=0, state S_DONE.
//   Total latency from equals se to valid: 1+RESW (add/sub/mul), 1+OPW+RESW (div).
//  se while busy: ignored entirely.
//  S_DONE: digit -> A cleared and loaded with d, disp_neg=0, S_A. op: see CONFIGURATION.
//   Equals is ignored.
//  S_ERR: err=1, disp_bcd=0. Only clr/reset exit.
//  During S_A/S_B disp_bcd shows the operand being entered, zero-extended in the upper nibbles.
//  No arithmetic wraps: the max result (10**DIGITS-1)**2 fits RESW.
// CONFIGURATION
//  CALC_CHAIN_EN defined: op in S_DONE -> A=result, B cleared, op latched, S_B.
//   If result is negative or >= 10**DIGITS, go to S_ERR instead.
//  CALC_CHAIN_EN undefined: op in S_DONE is ignored; a new calculation must start with a digit.
// TESTING
//  Operation sequence notation: "digit 1" = KEY=10'b0000000001 then a set pulse; "Add" = Add=1
//   then a set pulse; "=" = a set pulse with nothing else asserted.
//  1. digit 1, Add, digit 5, = -> after 1+RESW cycles: valid=1, disp_bcd=...0006, led=DONE.
//  2. 1,2 Mul 3,4 = -> res_bin=408, disp_bcd=...0408, disp_neg=0.
//  3. 1,0,0 Div 7 = -> res_bin=14 at 1+OPW+RESW cycles; 3 Sub 8 = -> disp_bcd=5, disp_neg=1.
//  4. 9 Div 0 = -> err=1, led=5'b10000; set ignored; clr -> led=5'b00001, err=0.
//  5. 1,2,3,4,5 with DIGITS=4 -> entry=1234. Held set=1 gives one entry only.
//   rst_n=0 mid-divide -> all outputs at reset values, no valid pulse.
//  6. CALC_CHAIN_EN: 2 Add 3 =, Add 4 = -> 9. Without the macro the second Add is ignored.

Source files
------------

// File: rtl/calc_core_n.sv
// rtl/calc_core_n.sv - multi-digit keypad calculator core with iterative divide and BCD result
// Optional: CALC_CHAIN_EN lets an operator in the done state reuse the result as operand A.
module calc_core_n #(
  parameter int DIGITS = 4,
  parameter int OPW    = 14,
  parameter int RESW   = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set,
  input  logic [9:0]            KEY,
  input  logic                  Add,
  input  logic                  Sub,
  input  logic                  Mul,
  input  logic                  Div,
  input  logic                  clr,
  output logic [8*DIGITS-1:0]   disp_bcd,
  output logic                  disp_neg,
  output logic [RESW-1:0]       res_bin,
  output logic                  busy,
  output logic                  valid,
  output logic                  err,
  output logic [4:0]            led
);

  localparam int BW = 8 * DIGITS;
  localparam int EW = 4 * DIGITS;
  localparam int CW = $clog2(RESW + 1);
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [RESW-1:0] LIMIT = RESW'(10 ** DIGITS);

  typedef enum logic [2:0] {S_A, S_B, S_CALC, S_DIV, S_BCD, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t           state, state_next;
  op_t              op_q, op_sel;
  logic             set_d;
  logic [OPW-1:0]   a, b;
  logic [EW-1:0]    entry;
  logic [NW-1:0]    n_ent;
  logic [CW-1:0]    cnt;
  logic [RESW-1:0]  res_val, calc_val;
  logic             neg_q, calc_neg;
  logic [RESW-1:0]  bin_sh, bin_next;
  logic [BW-1:0]    bcd_sh, bcd_adj, bcd_next, res_bcd;
  logic [OPW-1:0]   quot, rem, quot_next, rem_next;
  logic [OPW:0]     rem_sh;
  logic [3:0]       ops, digit;
  logic             se, key_one, op_one, is_digit, is_op, is_eq, entry_room, chain_ok;
  logic [OPW-1:0]   a_ins, b_ins;
  logic [EW-1:0]    entry_ins;

  // Entry decode: only clean one-hot digit, single operator, or bare equals act.
  assign se       = set & ~set_d;
  assign ops      = {Add, Sub, Mul, Div};
  assign key_one  = (KEY != '0) && ((KEY & (KEY - 10'd1)) == '0);
  assign op_one   = (ops != '0) && ((ops & (ops - 4'd1)) == '0);
  assign is_digit = se && key_one && (ops == '0);
  assign is_op    = se && (KEY == '0) && op_one;
  assign is_eq    = se && (KEY == '0) && (ops == '0);

  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++)
      if (KEY[i]) digit = 4'(i);
  end

  always_comb begin
    op_sel = OP_ADD;
    if (Sub) op_sel = OP_SUB;
    if (Mul) op_sel = OP_MUL;
    if (Div) op_sel = OP_DIV;
  end

  assign entry_room = n_ent < NW'(DIGITS);
  assign a_ins      = a * OPW'(10) + OPW'(digit);
  assign b_ins      = b * OPW'(10) + OPW'(digit);
  assign entry_ins  = {entry[EW-5:0], digit};
  assign chain_ok   = !disp_neg && (res_bin < LIMIT);

  always_comb begin
    calc_val = '0;
    calc_neg = 1'b0;
    case (op_q)
      OP_ADD: calc_val = RESW'(a) + RESW'(b);
      OP_SUB: begin
        if (a < b) begin
          calc_val = RESW'(b - a);
          calc_neg = 1'b1;
        end else begin
          calc_val = RESW'(a - b);
        end
      end
      OP_MUL: calc_val = RESW'(a) * RESW'(b);
      default: calc_val = '0;
    endcase
  end

  // One restoring-divide step: quotient bits shift in at the bottom as dividend bits leave the top.
  assign rem_sh = {rem, quot[OPW-1]};
  always_comb begin
    rem_next  = rem_sh[OPW-1:0];
    quot_next = {quot[OPW-2:0], 1'b0};
    if (rem_sh >= {1'b0, b}) begin
      rem_next  = OPW'(rem_sh - {1'b0, b});
      quot_next = {quot[OPW-2:0], 1'b1};
    end
  end

  // One double-dabble step.
  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < 2 * DIGITS; i++)
      if (bcd_sh[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
    {bcd_next, bin_next} = {bcd_adj, bin_sh} << 1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_A:    if (is_op) state_next = S_B;
      S_B:    if (is_eq) state_next = S_CALC;
      S_CALC: begin
        if (op_q == OP_DIV) state_next = (b == '0) ? S_ERR : S_DIV;
        else                state_next = S_BCD;
      end
      S_DIV:  if (cnt == CW'(OPW - 1))  state_next = S_BCD;
      S_BCD:  if (cnt == CW'(RESW - 1)) state_next = S_DONE;
      S_DONE: begin
        if (is_digit) state_next = S_A;
`ifdef CALC_CHAIN_EN
        else if (is_op) state_next = chain_ok ? S_B : S_ERR;
`endif
      end
      S_ERR:  state_next = S_ERR;
      default: state_next = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) set_d <= 1'b0;
    else        set_d <= set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) state <= S_A;
    else               state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      op_q     <= OP_ADD;
      a        <= '0;
      b        <= '0;
      entry    <= '0;
      n_ent    <= '0;
      cnt      <= '0;
      res_val  <= '0;
      neg_q    <= 1'b0;
      bin_sh   <= '0;
      bcd_sh   <= '0;
      quot     <= '0;
      rem      <= '0;
      res_bcd  <= '0;
      disp_neg <= 1'b0;
      res_bin  <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_A: begin
          if (is_digit && entry_room) begin
            a     <= a_ins;
            entry <= entry_ins;
            n_ent <= n_ent + NW'(1);
          end else if (is_op) begin
            op_q  <= op_sel;
            entry <= '0;
            n_ent <= '0;
          end
        end
        S_B: begin
          if (is_digit && entry_room) begin
            b     <= b_ins;
            entry <= entry_ins;
            n_ent <= n_ent + NW'(1);
          end
        end
        S_CALC: begin
          cnt    <= '0;
          bcd_sh <= '0;
          quot   <= a;
          rem    <= '0;
          res_val <= calc_val;
          neg_q   <= calc_neg;
          bin_sh  <= calc_val;
        end
        S_DIV: begin
          quot <= quot_next;
          rem  <= rem_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(OPW - 1)) begin
            cnt     <= '0;
            res_val <= RESW'(quot_next);
            neg_q   <= 1'b0;
            bin_sh  <= RESW'(quot_next);
            bcd_sh  <= '0;
          end
        end
        S_BCD: begin
          bcd_sh <= bcd_next;
          bin_sh <= bin_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(RESW - 1)) begin
            res_bcd  <= bcd_next;
            res_bin  <= res_val;
            disp_neg <= neg_q;
            valid    <= 1'b1;
          end
        end
        S_DONE: begin
          if (is_digit) begin
            a        <= OPW'(digit);
            b        <= '0;
            entry    <= EW'(digit);
            n_ent    <= NW'(1);
            disp_neg <= 1'b0;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op && chain_ok) begin
            a     <= res_bin[OPW-1:0];
            b     <= '0;
            op_q  <= op_sel;
            entry <= '0;
            n_ent <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_DIV) || (state == S_BCD);
  assign err  = (state == S_ERR);
  assign led  = {err, state == S_DONE, busy, state == S_B, state == S_A};

  always_comb begin
    case (state)
      S_A, S_B: disp_bcd = BW'(entry);
      S_ERR:    disp_bcd = '0;
      default:  disp_bcd = res_bcd;
    endcase
  end

endmodule

// File: tb/tb_calc_core_n.sv
// tb/tb_calc_core_n.sv - scoreboard bench for calc_core_n (optional CALC_CHAIN_EN)
module tb_calc_core_n;
  localparam int DIGITS = 4;
  localparam int OPW    = 14;
  localparam int RESW   = 28;
  localparam int LAT    = 1 + RESW;
  localparam int LATD   = 1 + OPW + RESW;

  logic              clk = 1'b0;
  logic              rst_n, set, Add, Sub, Mul, Div, clr;
  logic [9:0]        KEY;
  logic [8*DIGITS-1:0] disp_bcd;
  logic              disp_neg, busy, valid, err;
  logic [RESW-1:0]   res_bin;
  logic [4:0]        led;

  calc_core_n #(.DIGITS(DIGITS), .OPW(OPW), .RESW(RESW)) dut (
    .clk(clk), .rst_n(rst_n), .set(set), .KEY(KEY), .Add(Add), .Sub(Sub), .Mul(Mul),
    .Div(Div), .clr(clr), .disp_bcd(disp_bcd), .disp_neg(disp_neg), .res_bin(res_bin),
    .busy(busy), .valid(valid), .err(err), .led(led)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] bcd;
    logic        neg;
    logic [27:0] bin;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_se = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_bcd", 64'(disp_bcd), 64'(e.bcd));
        chk("res_neg", 64'(disp_neg), 64'(e.neg));
        chk("res_bin", 64'(res_bin), 64'(e.bin));
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
        chk("busy_at_valid", 64'(busy), 64'd0);
      end
    end
  end

  task automatic pulse(input logic [9:0] k, input logic [3:0] o);
    @(negedge clk);
    KEY = k;
    {Add, Sub, Mul, Div} = o;
    set = 1'b1;
    last_se = cyc + 1;
    @(negedge clk);
    set = 1'b0;
    KEY = '0;
    {Add, Sub, Mul, Div} = 4'b0000;
    @(negedge clk);
  endtask

  task automatic dig(input int d);
    logic [9:0] k;
    k = 10'b1 << d;
    pulse(k, 4'b0000);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic calc_eq(input logic [31:0] bcd, input logic neg, input logic [27:0] bin,
                         input int lat);
    exp_t e;
    pulse(10'b0, 4'b0000);
    e.bcd = bcd; e.neg = neg; e.bin = bin; e.lat = lat; e.start = last_se;
    sb.push_back(e);
    wait_done();
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  localparam logic [3:0] OA = 4'b1000, OS = 4'b0100, OM = 4'b0010, OD = 4'b0001;

  initial begin
    rst_n = 1'b0; set = 1'b0; KEY = '0; Add = 0; Sub = 0; Mul = 0; Div = 0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_disp", 64'(disp_bcd), 64'd0);
    chk("rst_led", 64'(led), 64'b00001);
    chk("rst_flags", 64'({busy, valid, err, disp_neg}), 64'd0);
    chk("rst_res", 64'(res_bin), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    dig(1);
    chk("entry_a", 64'(disp_bcd), 64'h1);
    pulse('0, OA);
    chk("led_b", 64'(led), 64'b00010);
    dig(5);
    chk("entry_b", 64'(disp_bcd), 64'h5);
    calc_eq(32'h6, 1'b0, 28'd6, LAT);
    chk("led_done", 64'(led), 64'b01000);

    dig(1); dig(2); pulse('0, OM); dig(3); dig(4);
    calc_eq(32'h408, 1'b0, 28'd408, LAT);

    dig(1); dig(0); dig(0); pulse('0, OD); dig(7);
    calc_eq(32'h14, 1'b0, 28'd14, LATD);
    dig(3); pulse('0, OS); dig(8);
    calc_eq(32'h5, 1'b1, 28'd5, LAT);
    dig(7); pulse('0, OS); dig(7);
    calc_eq(32'h0, 1'b0, 28'd0, LAT);

    dig(9); pulse('0, OD); dig(0); pulse('0, 4'b0000);
    repeat (2) @(negedge clk);
    chk("div0_err", 64'(err), 64'd1);
    chk("div0_led", 64'(led), 64'b10000);
    chk("div0_disp", 64'(disp_bcd), 64'd0);
    dig(1);
    chk("err_sticky", 64'(led), 64'b10000);
    do_clr();
    chk("clr_led", 64'(led), 64'b00001);
    chk("clr_err", 64'(err), 64'd0);

    @(negedge clk);
    KEY = 10'b1 << 7; set = 1'b1;
    repeat (5) @(negedge clk);
    set = 1'b0; KEY = '0;
    @(negedge clk);
    chk("held_set", 64'(disp_bcd), 64'h7);
    do_clr();
    dig(1); dig(2); dig(3); dig(4); dig(5);
    chk("digit_limit", 64'(disp_bcd), 64'h1234);
    pulse(10'b0000000011, 4'b0000);
    pulse('0, OA | OM);
    chk("multihot_ignored", 64'(led), 64'b00001);
    pulse('0, OM); dig(9); dig(9); dig(9); dig(9);
    calc_eq(32'h12338766, 1'b0, 28'd12338766, LAT);

    dig(9); dig(9); dig(9); dig(9); pulse('0, OD); dig(3); pulse('0, 4'b0000);
    repeat (8) @(negedge clk);
    chk("mid_div_busy", 64'(busy), 64'd1);
    chk("mid_div_led", 64'(led), 64'b00100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_disp", 64'(disp_bcd), 64'd0);
    chk("abort_res", 64'(res_bin), 64'd0);
    chk("abort_led", 64'(led), 64'b00001);
    chk("abort_flags", 64'({busy, err, disp_neg}), 64'd0);
    repeat (80) @(negedge clk);

    dig(2); pulse('0, OA); dig(3);
    calc_eq(32'h5, 1'b0, 28'd5, LAT);
    pulse('0, OA);
    dig(4);
`ifdef CALC_CHAIN_EN
    calc_eq(32'h9, 1'b0, 28'd9, LAT);
`else
    pulse('0, 4'b0000);
    repeat (40) @(negedge clk);
    chk("nochain_led", 64'(led), 64'b00001);
    chk("nochain_disp", 64'(disp_bcd), 64'h4);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
